hall_call_panel: RTL
====================

// Module: hall_call_panel
// PURPOSE
//  Hallway-side initiator of the hall-call protocol. Captures up/down button presses on every floor
//  and drives lamps. Serialises pending calls, one at a time, onto hall_request/hall_request_valid
//  towards building_controller and holds each until request_ack. Clears a call when a car reports service.
// PARAMETERS
//  FLOOR_COUNT   7   floors served, index 0 = ground
//  FLOOR_WIDTH   3   floor index width; FLOOR_COUNT <= 2**FLOOR_WIDTH
//  ACK_TIMEOUT   15  cycles hall_request_valid is held without ack before withdrawal
// PORTS
//  clk                 in   1            system clock, all logic on rising edge
//  reset               in   1            synchronous, active-high
//  btn_up              in   FLOOR_COUNT  up button per floor, level; bit FLOOR_COUNT-1 ignored
//  btn_down            in   FLOOR_COUNT  down button per floor, level; bit 0 ignored
//  served_valid        in   1            car has opened doors for a hall call (1-cycle pulse)
//  served_floor        in   FLOOR_WIDTH  floor of served call
//  served_up_ndown     in   1            direction of served call, 1=up
//  hall_request        out  FLOOR_WIDTH+1 {up_ndown, floor}; bit 3 = direction, [2:0] = floor
//  hall_request_valid  out  1            request offered to building controller
//  request_ack         in   1            building controller accepted current request
//  lamp_up             out  FLOOR_COUNT  up call lamp per floor
//  lamp_down           out  FLOOR_COUNT  down call lamp per floor
// BEHAVIOUR
//  - Reset: hall_request=0, hall_request_valid=0, lamps=0, all calls cleared, FSM=IDLE,
//    rr pointer=2*FLOOR_COUNT-1, button history=0 (a button held through reset registers as a press).
//  - Call slots: slot = 2*floor + (down?1:0). Each slot is FREE, UNSENT or SENT.
//    Lamp for a slot = UNSENT|SENT.
//  - Press = rising edge of the button vs previous cycle. A press on a FREE valid slot makes it UNSENT.
//    The lamp is high the next cycle. Presses on UNSENT/SENT or invalid slots (up at top, down at 0) are ignored.
//  - Service: served_valid with a valid slot makes that slot FREE next cycle, whatever its state.
//    served_floor >= FLOOR_COUNT is ignored. Press and service on the same slot in the same cycle: service wins, slot FREE.
//  - FSM IDLE: if any slot is UNSENT, pick the first UNSENT slot searching from pointer+1 with wrap.
//    Register it onto hall_request, assert hall_request_valid next cycle, go REQ, start timeout counter at 0.
//  - FSM REQ: hall_request and valid are held stable. request_ack=1 -> slot becomes SENT, pointer=slot.
//    valid=0 next cycle, go IDLE. Counter reaches ACK_TIMEOUT-1 without ack -> valid=0 next cycle.
//    Slot stays UNSENT, pointer=slot (fairness), go IDLE.
//  - In-flight slot served while in REQ: withdraw, valid=0 next cycle, go IDLE, slot FREE.
//    If ack arrives in the same cycle, service wins.
//  - request_ack while hall_request_valid=0 is ignored. At most one request outstanding.
//    At least one cycle with valid low between requests.
//  - Latency: press edge sampled at cycle N -> lamp at N+1 -> valid at N+2 at the earliest.
//  - Reset mid-REQ: valid drops the cycle after reset is sampled; no ack is required.
// TESTING
//  1 btn_up[2] high at cycle 5 -> lamp_up[2]=1 @6, valid=1 hall_request=4'b1010 @7.
//    Ack @9 -> valid=0 @10, lamp_up[2] stays 1.
//  2 Then served_valid, floor 2, up -> lamp_up[2]=0 next cycle. Re-press -> new request 4'b1010.
//  3 Same-cycle presses up1, down3, up5, each acked -> requests 4'b1001, 4'b0011, 4'b1101 in that order.
//  4 Single call, never acked -> valid high exactly 15 cycles, low 1+ cycles, same request reissued.
//    Lamp held throughout.
//  5 btn_up[6] and btn_down[0] -> no lamp, no request. Service of floor 2 up during REQ for that
//    call -> valid drops next cycle.
//  6 Reset asserted in REQ with lamps lit -> next cycle valid=0, all lamps 0, no request after release.

Source files
------------

// File: rtl/hall_call_panel.sv
// Hall-call panel: latches up/down presses per floor, drives lamps and
// offers pending calls one at a time to the building controller.
module hall_call_panel #(
  parameter int FLOOR_COUNT = 7,
  parameter int FLOOR_WIDTH = 3,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [FLOOR_COUNT-1:0] btn_up,
  input  logic [FLOOR_COUNT-1:0] btn_down,
  input  logic                   served_valid,
  input  logic [FLOOR_WIDTH-1:0] served_floor,
  input  logic                   served_up_ndown,
  output logic [FLOOR_WIDTH:0]   hall_request,
  output logic                   hall_request_valid,
  input  logic                   request_ack,
  output logic [FLOOR_COUNT-1:0] lamp_up,
  output logic [FLOOR_COUNT-1:0] lamp_down
);

  localparam int NS = 2 * FLOOR_COUNT;
  localparam int PW = $clog2(NS);
  localparam int CW = $clog2(ACK_TIMEOUT + 1);

  typedef enum logic {IDLE, REQ} state_e;

  logic [FLOOR_COUNT-1:0] btn_up_q;
  logic [FLOOR_COUNT-1:0] btn_down_q;
  logic [NS-1:0]          unsent_q, unsent_d;
  logic [NS-1:0]          sent_q, sent_d;
  logic [PW-1:0]          ptr_q;
  logic [PW-1:0]          slot_q;
  logic [CW-1:0]          cnt_q;
  logic [FLOOR_WIDTH:0]   req_q;
  logic                   valid_q;
  state_e                 state_q;

  logic [FLOOR_COUNT-1:0] press_up, press_dn;
  logic [NS-1:0]          press, valid_mask, free;
  logic [NS-1:0]          serve_mask, slot_hot, ack_mask, cand;
  logic [FLOOR_WIDTH:0]   serve_slot;
  logic                   served_ok, inflight_hit, ack_fire;
  logic                   pick_found;
  logic [PW-1:0]          pick_slot;

  localparam logic [NS-1:0] ONE = {{(NS-1){1'b0}}, 1'b1};

  assign hall_request       = req_q;
  assign hall_request_valid = valid_q;

  always_comb begin
    press_up   = btn_up & ~btn_up_q;
    press_dn   = btn_down & ~btn_down_q;
    press      = '0;
    lamp_up    = '0;
    lamp_down  = '0;
    valid_mask = '1;
    // No down call from the ground floor, no up call from the top floor
    valid_mask[1]    = 1'b0;
    valid_mask[NS-2] = 1'b0;
    for (int f = 0; f < FLOOR_COUNT; f++) begin
      press[2*f]   = press_up[f];
      press[2*f+1] = press_dn[f];
      lamp_up[f]   = unsent_q[2*f] | sent_q[2*f];
      lamp_down[f] = unsent_q[2*f+1] | sent_q[2*f+1];
    end
  end

  always_comb begin
    serve_slot   = {served_floor, ~served_up_ndown};
    served_ok    = served_valid &&
                   ({1'b0, served_floor} < (FLOOR_WIDTH+1)'(FLOOR_COUNT));
    serve_mask   = served_ok ? (ONE << serve_slot) : '0;
    slot_hot     = ONE << slot_q;
    inflight_hit = |(serve_mask & slot_hot);
    ack_fire     = (state_q == REQ) && request_ack && !inflight_hit;
    ack_mask     = ack_fire ? slot_hot : '0;
    free         = ~(unsent_q | sent_q);
    unsent_d     = (unsent_q | (press & free & valid_mask))
                   & ~ack_mask & ~serve_mask;
    sent_d       = (sent_q | ack_mask) & ~serve_mask;
    cand         = unsent_q & ~serve_mask;
  end

  // Round-robin search for the first unsent slot after the pointer
  always_comb begin
    pick_found = 1'b0;
    pick_slot  = '0;
    for (int i = 0; i < NS; i++) begin
      int idx;
      idx = int'(ptr_q) + 1 + i;
      if (idx >= NS) idx = idx - NS;
      if (!pick_found && cand[idx]) begin
        pick_found = 1'b1;
        pick_slot  = PW'(idx);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      btn_up_q   <= '0;
      btn_down_q <= '0;
      unsent_q   <= '0;
      sent_q     <= '0;
      ptr_q      <= PW'(NS - 1);
      slot_q     <= '0;
      cnt_q      <= '0;
      req_q      <= '0;
      valid_q    <= 1'b0;
      state_q    <= IDLE;
    end else begin
      btn_up_q   <= btn_up;
      btn_down_q <= btn_down;
      unsent_q   <= unsent_d;
      sent_q     <= sent_d;
      unique case (state_q)
        IDLE: begin
          if (pick_found) begin
            req_q   <= {~pick_slot[0], FLOOR_WIDTH'(pick_slot >> 1)};
            slot_q  <= pick_slot;
            valid_q <= 1'b1;
            cnt_q   <= '0;
            state_q <= REQ;
          end
        end
        REQ: begin
          if (inflight_hit) begin
            valid_q <= 1'b0;
            state_q <= IDLE;
          end else if (request_ack ||
                       cnt_q == CW'(ACK_TIMEOUT - 1)) begin
            valid_q <= 1'b0;
            ptr_q   <= slot_q;
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
      endcase
    end
  end

endmodule
